// File: rtl/tlul_axi_bridge_mo.sv
// TL-UL to AXI4 bridge: one AXI request in flight from a single issue register,
// up to MaxOutstanding TL-UL transactions tracked and answered strictly in order.
package tlul_pkg;
   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;
endpackage

package axi_pkg;
   typedef struct packed {
      logic        aw_valid;
      logic [31:0] aw_addr;
      logic        aw_id;
      logic [7:0]  aw_len;
      logic [2:0]  aw_size;
      logic [1:0]  aw_burst;
      logic [2:0]  aw_prot;
      logic [3:0]  aw_cache;
      logic [3:0]  aw_qos;
      logic        w_valid;
      logic [31:0] w_data;
      logic [3:0]  w_strb;
      logic        w_last;
      logic        b_ready;
      logic        ar_valid;
      logic [31:0] ar_addr;
      logic        ar_id;
      logic [7:0]  ar_len;
      logic [2:0]  ar_size;
      logic [1:0]  ar_burst;
      logic [2:0]  ar_prot;
      logic [3:0]  ar_cache;
      logic [3:0]  ar_qos;
      logic        r_ready;
   } axi_req_t;

   typedef struct packed {
      logic        aw_ready;
      logic        w_ready;
      logic        b_valid;
      logic        b_id;
      logic [1:0]  b_resp;
      logic        ar_ready;
      logic        r_valid;
      logic        r_id;
      logic [31:0] r_data;
      logic [1:0]  r_resp;
      logic        r_last;
   } axi_rsp_t;
endpackage

module tlul_axi_bridge_mo #(
   parameter int unsigned MaxOutstanding = 4,
   parameter logic [31:0] BaseAddr       = 32'h8000_0000,
   parameter logic [31:0] WindowSize     = 32'h4000_0000,
   parameter type         axi_req_t      = axi_pkg::axi_req_t,
   parameter type         axi_rsp_t      = axi_pkg::axi_rsp_t
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  tlul_pkg::tl_h2d_t tl_i,
   output tlul_pkg::tl_d2h_t tl_o,
   output axi_req_t          axi_req_o,
   input  axi_rsp_t          axi_rsp_i,
   output logic [4:0]        outstanding_o,
   output logic [15:0]       err_count_o
);
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

   typedef struct packed {
      logic       wr;
      logic [7:0] source;
      logic [1:0] size;
      logic       err;
   } trk_t;

   logic            aw_pend_q, aw_pend_d, w_pend_q, w_pend_d, ar_pend_q, ar_pend_d;
   logic [31:0]     iss_addr_q, iss_addr_d, iss_data_q, iss_data_d;
   logic [1:0]      iss_size_q, iss_size_d;
   logic [3:0]      iss_mask_q, iss_mask_d;
   trk_t            trk_q [MaxOutstanding];
   trk_t            trk_d [MaxOutstanding];
   logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [4:0]      cnt_q, cnt_d, out_q, out_d;
   logic            d_vld_q, d_vld_d, d_get_q, d_get_d, d_err_q, d_err_d;
   logic [7:0]      d_source_q, d_source_d;
   logic [1:0]      d_size_q, d_size_d;
   logic [31:0]     d_data_q, d_data_d;
   logic [15:0]     errc_q, errc_d;

   logic a_ready, a_hs, is_get, is_put, loc_err, head_vld, d_free;
   logic r_ready, b_ready, r_hs, b_hs, d_load, d_hs, rsp_err;
   trk_t head;
   logic unused_sig;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
   endfunction

   // The tracking FIFO pops when a response moves into the D register; the
   // outstanding counter follows the D handshake so a_ready still sees it.
   always_comb begin
      a_ready  = ~rst_i & ~(aw_pend_q | w_pend_q | ar_pend_q) & (out_q < 5'(MaxOutstanding));
      a_hs     = tl_i.a_valid & a_ready;
      is_get   = (tl_i.a_opcode == 3'd4);
      is_put   = (tl_i.a_opcode == 3'd0) | (tl_i.a_opcode == 3'd1);
      loc_err  = ~(is_get | is_put) | ((tl_i.a_address - BaseAddr) >= WindowSize);
      head     = trk_q[rptr_q];
      head_vld = (cnt_q != '0);
      d_free   = ~d_vld_q | tl_i.d_ready;
      r_ready  = ~rst_i & head_vld & ~head.err & ~head.wr & d_free;
      b_ready  = ~rst_i & head_vld & ~head.err & head.wr & d_free;
      r_hs     = r_ready & axi_rsp_i.r_valid;
      b_hs     = b_ready & axi_rsp_i.b_valid;
      d_load   = (head_vld & head.err & d_free) | r_hs | b_hs;
      d_hs     = ~rst_i & d_vld_q & tl_i.d_ready;
      rsp_err  = (r_hs & axi_rsp_i.r_resp[1]) | (b_hs & axi_rsp_i.b_resp[1]);
   end

   always_comb begin
      aw_pend_d  = aw_pend_q & ~axi_rsp_i.aw_ready;
      w_pend_d   = w_pend_q & ~axi_rsp_i.w_ready;
      ar_pend_d  = ar_pend_q & ~axi_rsp_i.ar_ready;
      iss_addr_d = iss_addr_q;
      iss_data_d = iss_data_q;
      iss_size_d = iss_size_q;
      iss_mask_d = iss_mask_q;
      trk_d      = trk_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      cnt_d      = cnt_q + 5'(a_hs) - 5'(d_load);
      out_d      = out_q + 5'(a_hs) - 5'(d_hs);
      d_vld_d    = d_vld_q & ~tl_i.d_ready;
      d_get_d    = d_get_q;
      d_err_d    = d_err_q;
      d_source_d = d_source_q;
      d_size_d   = d_size_q;
      d_data_d   = d_data_q;
      errc_d     = errc_q;
      if (a_hs) begin
         trk_d[wptr_q] = '{wr: ~is_get, source: tl_i.a_source, size: tl_i.a_size, err: loc_err};
         wptr_d        = ptr_inc(wptr_q);
         if (!loc_err) begin
            ar_pend_d  = is_get;
            aw_pend_d  = is_put;
            w_pend_d   = is_put;
            iss_addr_d = tl_i.a_address;
            iss_data_d = tl_i.a_data;
            iss_size_d = tl_i.a_size;
            iss_mask_d = tl_i.a_mask;
         end
      end
      if (d_load) begin
         rptr_d     = ptr_inc(rptr_q);
         d_vld_d    = 1'b1;
         d_get_d    = ~head.wr;
         d_err_d    = head.err | rsp_err;
         d_source_d = head.source;
         d_size_d   = head.size;
         d_data_d   = (r_hs & ~axi_rsp_i.r_resp[1]) ? axi_rsp_i.r_data : '0;
      end
      if (d_hs && d_err_q && errc_q != 16'hFFFF) errc_d = errc_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         aw_pend_q  <= 1'b0;
         w_pend_q   <= 1'b0;
         ar_pend_q  <= 1'b0;
         iss_addr_q <= '0;
         iss_data_q <= '0;
         iss_size_q <= '0;
         iss_mask_q <= '0;
         trk_q      <= '{default: '0};
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         out_q      <= '0;
         d_vld_q    <= 1'b0;
         d_get_q    <= 1'b0;
         d_err_q    <= 1'b0;
         d_source_q <= '0;
         d_size_q   <= '0;
         d_data_q   <= '0;
         errc_q     <= '0;
      end else begin
         aw_pend_q  <= aw_pend_d;
         w_pend_q   <= w_pend_d;
         ar_pend_q  <= ar_pend_d;
         iss_addr_q <= iss_addr_d;
         iss_data_q <= iss_data_d;
         iss_size_q <= iss_size_d;
         iss_mask_q <= iss_mask_d;
         trk_q      <= trk_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         out_q      <= out_d;
         d_vld_q    <= d_vld_d;
         d_get_q    <= d_get_d;
         d_err_q    <= d_err_d;
         d_source_q <= d_source_d;
         d_size_q   <= d_size_d;
         d_data_q   <= d_data_d;
         errc_q     <= errc_d;
      end
   end

   always_comb begin
      tl_o           = '0;
      tl_o.a_ready   = a_ready;
      tl_o.d_valid   = d_vld_q & ~rst_i;
      tl_o.d_opcode  = d_get_q ? 3'd1 : 3'd0;
      tl_o.d_size    = d_size_q;
      tl_o.d_source  = d_source_q;
      tl_o.d_data    = d_data_q;
      tl_o.d_error   = d_err_q;
      axi_req_o          = '0;
      axi_req_o.aw_valid = aw_pend_q & ~rst_i;
      axi_req_o.aw_addr  = iss_addr_q;
      axi_req_o.aw_size  = {1'b0, iss_size_q};
      axi_req_o.aw_burst = 2'b01;
      axi_req_o.w_valid  = w_pend_q & ~rst_i;
      axi_req_o.w_data   = iss_data_q;
      axi_req_o.w_strb   = iss_mask_q;
      axi_req_o.w_last   = 1'b1;
      axi_req_o.b_ready  = b_ready;
      axi_req_o.ar_valid = ar_pend_q & ~rst_i;
      axi_req_o.ar_addr  = iss_addr_q;
      axi_req_o.ar_size  = {1'b0, iss_size_q};
      axi_req_o.ar_burst = 2'b01;
      axi_req_o.r_ready  = r_ready;
      outstanding_o      = rst_i ? 5'd0 : out_q;
      err_count_o        = rst_i ? 16'd0 : errc_q;
   end

   assign unused_sig = ^{tl_i.a_param, axi_rsp_i.b_id, axi_rsp_i.b_resp[0], axi_rsp_i.r_id,
                         axi_rsp_i.r_resp[0], axi_rsp_i.r_last};
endmodule

// File: tb/tb_tlul_axi_bridge_mo.sv
// Directed plus randomized bench: an AXI slave model with random stalls and a
// transaction-level scoreboard of expected AXI requests and TL-UL responses.
module tb_tlul_axi_bridge_mo;
   import tlul_pkg::*;
   import axi_pkg::*;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam logic [31:0] WSZ  = 32'h4000_0000;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   tl_h2d_t    tl_i, a_drv;
   logic       d_rdy = 1'b1;
   tl_d2h_t    tl_o;
   axi_req_t   axi_req_o;
   axi_rsp_t   axi_rsp_i = '0;
   logic [4:0] outstanding_o;
   logic [15:0] err_count_o;

   always #5 clk_i = ~clk_i;

   always_comb begin
      tl_i         = a_drv;
      tl_i.d_ready = d_rdy;
   end

   tlul_axi_bridge_mo #(.MaxOutstanding(4), .BaseAddr(BASE), .WindowSize(WSZ),
                        .axi_req_t(axi_req_t), .axi_rsp_t(axi_rsp_t)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .tl_i(tl_i), .tl_o(tl_o),
      .axi_req_o(axi_req_o), .axi_rsp_i(axi_rsp_i),
      .outstanding_o(outstanding_o), .err_count_o(err_count_o));

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Slave behaviour as a function of address
   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      return (a == 32'h8000_0010) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B1) ^ 32'h1234_5678);
   endfunction
   function automatic logic [1:0] resp_fn(input logic [31:0] a);
      case (a[5:2])
         4'hF:    return 2'b10;
         4'hE:    return 2'b11;
         4'hD:    return 2'b01;
         default: return 2'b00;
      endcase
   endfunction
   function automatic bit in_window(input logic [31:0] a);
      return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + longint'(WSZ));
   endfunction

   typedef struct packed { logic [31:0] addr; logic [1:0] size; } exp_a_t;
   typedef struct packed { logic [31:0] data; logic [3:0] mask; } exp_w_t;
   typedef struct { logic [2:0] op; logic [7:0] src; logic [1:0] size; logic [31:0] data; logic err; } exp_d_t;

   exp_a_t exp_ar[$], exp_aw[$];
   exp_w_t exp_w[$];
   exp_d_t exp_d[$];
   int     d_hs_cnt = 0, exp_errs = 0;

   int rdy_pct = 100, rsp_pct = 100, dr_pct = 100;
   bit r_stall = 0, b_stall = 0;

   logic [31:0] rq[$], bq[$];
   int          wcnt = 0;
   bit          ar_f, aw_f, w_f, r_f, b_f;
   logic [31:0] ar_fa, aw_fa;
   exp_a_t      m_a;
   exp_w_t      m_w;
   exp_d_t      m_d;

   // Monitor: observe handshakes that will complete at the next rising edge.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (axi_req_o.ar_valid && axi_rsp_i.ar_ready) begin
            ar_f = 1; ar_fa = axi_req_o.ar_addr;
            chk("ar_expected", 32'(exp_ar.size() > 0), 1);
            if (exp_ar.size() > 0) begin
               m_a = exp_ar.pop_front();
               chk("ar_addr", axi_req_o.ar_addr, m_a.addr);
               chk("ar_size", 32'(axi_req_o.ar_size), 32'(m_a.size));
               chk("ar_len", 32'(axi_req_o.ar_len), 0);
               chk("ar_burst", 32'(axi_req_o.ar_burst), 1);
            end
         end
         if (axi_req_o.aw_valid && axi_rsp_i.aw_ready) begin
            aw_f = 1; aw_fa = axi_req_o.aw_addr;
            chk("aw_expected", 32'(exp_aw.size() > 0), 1);
            if (exp_aw.size() > 0) begin
               m_a = exp_aw.pop_front();
               chk("aw_addr", axi_req_o.aw_addr, m_a.addr);
               chk("aw_len", 32'(axi_req_o.aw_len), 0);
            end
         end
         if (axi_req_o.w_valid && axi_rsp_i.w_ready) begin
            w_f = 1;
            chk("w_expected", 32'(exp_w.size() > 0), 1);
            if (exp_w.size() > 0) begin
               m_w = exp_w.pop_front();
               chk("w_data", axi_req_o.w_data, m_w.data);
               chk("w_strb", 32'(axi_req_o.w_strb), 32'(m_w.mask));
               chk("w_last", 32'(axi_req_o.w_last), 1);
            end
         end
         if (axi_req_o.r_ready && axi_rsp_i.r_valid) r_f = 1;
         if (axi_req_o.b_ready && axi_rsp_i.b_valid) b_f = 1;
         if (tl_o.d_valid && tl_i.d_ready) begin
            d_hs_cnt++;
            chk("d_expected", 32'(exp_d.size() > 0), 1);
            if (exp_d.size() > 0) begin
               m_d = exp_d.pop_front();
               chk("d_opcode", 32'(tl_o.d_opcode), 32'(m_d.op));
               chk("d_source", 32'(tl_o.d_source), 32'(m_d.src));
               chk("d_size", 32'(tl_o.d_size), 32'(m_d.size));
               chk("d_data", tl_o.d_data, m_d.data);
               chk("d_error", 32'(tl_o.d_error), 32'(m_d.err));
               if (m_d.err) exp_errs++;
            end
         end
      end
   end

   // AXI slave model: in-order R and B, random readiness and response delay.
   always @(posedge clk_i) begin
      #1;
      if (rst_i) begin
         rq.delete(); bq.delete(); wcnt = 0;
         axi_rsp_i = '0; d_rdy = 1'b1;
         {ar_f, aw_f, w_f, r_f, b_f} = '0;
      end else begin
         if (ar_f) rq.push_back(ar_fa);
         if (aw_f) bq.push_back(aw_fa);
         if (w_f) wcnt++;
         if (r_f) begin void'(rq.pop_front()); axi_rsp_i.r_valid = 1'b0; end
         if (b_f) begin void'(bq.pop_front()); wcnt--; axi_rsp_i.b_valid = 1'b0; end
         {ar_f, aw_f, w_f, r_f, b_f} = '0;
         axi_rsp_i.ar_ready = ($urandom_range(99) < rdy_pct);
         axi_rsp_i.aw_ready = ($urandom_range(99) < rdy_pct);
         axi_rsp_i.w_ready  = ($urandom_range(99) < rdy_pct);
         if (!axi_rsp_i.r_valid && rq.size() > 0 && !r_stall && $urandom_range(99) < rsp_pct) begin
            axi_rsp_i.r_valid = 1'b1;
            axi_rsp_i.r_data  = rd_fn(rq[0]);
            axi_rsp_i.r_resp  = resp_fn(rq[0]);
            axi_rsp_i.r_last  = 1'b1;
         end
         if (!axi_rsp_i.b_valid && bq.size() > 0 && wcnt > 0 && !b_stall && $urandom_range(99) < rsp_pct) begin
            axi_rsp_i.b_valid = 1'b1;
            axi_rsp_i.b_resp  = resp_fn(bq[0]);
         end
         d_rdy = ($urandom_range(99) < dr_pct);
      end
   end

   task automatic tick();
      @(posedge clk_i); #2;
   endtask

   task automatic drive_a(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] src,
                          input logic [1:0] size, input logic [3:0] mask, input logic [31:0] data);
      a_drv           = '0;
      a_drv.a_valid   = 1'b1;
      a_drv.a_opcode  = op;
      a_drv.a_address = addr;
      a_drv.a_source  = src;
      a_drv.a_size    = size;
      a_drv.a_mask    = mask;
      a_drv.a_data    = data;
   endtask

   task automatic push_expect(input tl_h2d_t a);
      exp_d_t     e;
      logic [1:0] rs;
      bit         is_get, ok;
      is_get = (a.a_opcode == 3'd4);
      ok     = (is_get || a.a_opcode <= 3'd1) && in_window(a.a_address);
      rs     = resp_fn(a.a_address);
      e.op   = is_get ? 3'd1 : 3'd0;
      e.src  = a.a_source;
      e.size = a.a_size;
      e.err  = !ok || rs[1];
      e.data = (!e.err && is_get) ? rd_fn(a.a_address) : 32'd0;
      exp_d.push_back(e);
      if (ok && is_get) exp_ar.push_back('{addr: a.a_address, size: a.a_size});
      if (ok && !is_get) begin
         exp_aw.push_back('{addr: a.a_address, size: a.a_size});
         exp_w.push_back('{data: a.a_data, mask: a.a_mask});
      end
   endtask

   task automatic wait_accept();
      bit ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk_i);
         if (tl_o.a_ready) ok = 1;
      end
      chk("a_accept", 32'(ok), 1);
      @(posedge clk_i); #2;
      if (ok) push_expect(a_drv);
      a_drv.a_valid = 1'b0;
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] src,
                       input logic [1:0] size, input logic [3:0] mask, input logic [31:0] data);
      drive_a(op, addr, src, size, mask, data);
      wait_accept();
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         tick();
         done = (exp_d.size() == 0) && (outstanding_o == 5'd0);
      end
      chk("drain", 32'(done), 1);
   endtask

   initial begin
      int base_d;
      bit seen;
      a_drv = '0;
      repeat (3) tick();
      chk("rst_a_ready", 32'(tl_o.a_ready), 0);
      chk("rst_d_valid", 32'(tl_o.d_valid), 0);
      chk("rst_outstanding", 32'(outstanding_o), 0);
      chk("rst_err_count", 32'(err_count_o), 0);
      chk("rst_axi_valids", 32'({axi_req_o.ar_valid, axi_req_o.aw_valid, axi_req_o.w_valid}), 0);
      chk("rst_axi_readies", 32'({axi_req_o.r_ready, axi_req_o.b_ready}), 0);
      rst_i = 1'b0;
      tick();
      chk("idle_a_ready", 32'(tl_o.a_ready), 1);

      // Get in window, slave returns DEADBEEF
      send(3'd4, 32'h8000_0010, 8'd3, 2'd2, 4'hF, 32'd0);
      chk("get_ar_valid_next", 32'(axi_req_o.ar_valid), 1);
      wait_idle();
      chk("get_err_count", 32'(err_count_o), 0);

      // PutPartial with sparse mask
      send(3'd1, 32'h8000_0000, 8'd5, 2'd2, 4'b0101, 32'hCAFE_F00D);
      chk("put_aw_valid_next", 32'(axi_req_o.aw_valid), 1);
      chk("put_w_valid_next", 32'(axi_req_o.w_valid), 1);
      chk("put_wstrb", 32'(axi_req_o.w_strb), 32'h5);
      wait_idle();

      // Out-of-window Get: local error, no AXI traffic
      send(3'd4, 32'h1000_0000, 8'd7, 2'd2, 4'hF, 32'd0);
      chk("err_no_ar", 32'(axi_req_o.ar_valid), 0);
      wait_idle();
      chk("err_count_one", 32'(err_count_o), 1);

      // Fill to MaxOutstanding with R stalled
      r_stall = 1;
      for (int i = 0; i < 4; i++) send(3'd4, BASE + 32'h100 + 32'(i * 4), 8'(10 + i), 2'd2, 4'hF, 32'd0);
      tick();
      chk("full_outstanding", 32'(outstanding_o), 4);
      chk("full_a_ready", 32'(tl_o.a_ready), 0);
      drive_a(3'd4, BASE + 32'h200, 8'd20, 2'd2, 4'hF, 32'd0);
      base_d = d_hs_cnt;
      repeat (4) begin
         @(negedge clk_i);
         chk("full_a_ready_held", 32'(tl_o.a_ready), 0);
      end
      @(posedge clk_i); #2;
      r_stall = 0;
      wait_accept();
      chk("fifth_after_d", 32'(d_hs_cnt > base_d), 1);
      wait_idle();

      // Put then Get with B stalled: R must wait behind the write
      b_stall = 1;
      send(3'd0, BASE + 32'h40, 8'd30, 2'd2, 4'hF, 32'h1111_2222);
      send(3'd4, BASE + 32'h44, 8'd31, 2'd2, 4'hF, 32'd0);
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         tick();
         seen = axi_rsp_i.r_valid;
      end
      chk("r_presented", 32'(seen), 1);
      repeat (4) begin
         @(negedge clk_i);
         chk("r_ready_held", 32'(axi_req_o.r_ready), 0);
      end
      @(posedge clk_i); #2;
      b_stall = 0;
      wait_idle();

      // Reset with three in flight
      r_stall = 1;
      for (int i = 0; i < 3; i++) send(3'd4, BASE + 32'h300 + 32'(i * 4), 8'(40 + i), 2'd2, 4'hF, 32'd0);
      tick();
      chk("pre_rst_outstanding", 32'(outstanding_o), 3);
      rst_i = 1'b1;
      tick();
      exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_d.delete();
      exp_errs = 0;
      chk("mid_rst_outstanding", 32'(outstanding_o), 0);
      chk("mid_rst_d_valid", 32'(tl_o.d_valid), 0);
      chk("mid_rst_a_ready", 32'(tl_o.a_ready), 0);
      chk("mid_rst_err_count", 32'(err_count_o), 0);
      tick();
      chk("mid_rst_a_ready_hold", 32'(tl_o.a_ready), 0);
      r_stall = 0;
      rst_i = 1'b0;
      tick();
      chk("post_rst_a_ready", 32'(tl_o.a_ready), 1);
      chk("post_rst_outstanding", 32'(outstanding_o), 0);

      // Randomized traffic with window boundaries and illegal opcodes
      rdy_pct = 70; rsp_pct = 60; dr_pct = 70;
      for (int n = 0; n < 150; n++) begin
         logic [2:0]  op;
         logic [31:0] addr;
         int          r = $urandom_range(9);
         int          s = $urandom_range(11);
         if (r < 4)       op = 3'd4;
         else if (r < 6)  op = 3'd0;
         else if (r < 8)  op = 3'd1;
         else             op = 3'($urandom_range(2, 3) + ($urandom_range(1) * 3));
         if (s < 7)       addr = BASE + ($urandom() & (WSZ - 32'd1) & 32'hFFFF_FFFC);
         else if (s == 7) addr = BASE - 32'd4;
         else if (s == 8) addr = BASE + WSZ;
         else if (s == 9) addr = BASE + WSZ - 32'd4;
         else if (s == 10) addr = BASE;
         else             addr = 32'h1000_0000;
         send(op, addr, 8'($urandom()), 2'($urandom_range(2)), 4'($urandom()), $urandom());
         if ($urandom_range(3) == 0) tick();
      end
      wait_idle();
      chk("rand_outstanding", 32'(outstanding_o), 0);
      chk("rand_err_count", 32'(err_count_o), 32'(exp_errs));
      chk("rand_ar_left", 32'(exp_ar.size() + exp_aw.size() + exp_w.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
